// File: rtl/oscillator_bank.sv
// Time-multiplexed oscillator bank: NVOICES voices mixed into one offset-binary sample per frame.
// Optional noise waveform (LFSR) is built only when OSCILLATOR_BANK_NOISE_EN is defined.
module oscillator_bank #(
    parameter int NVOICES     = 4,
    parameter int BITDEPTH    = 14,
    parameter int BITFRACTION = 8
) (
    input  logic                       sample_clock,
    input  logic                       rst,
    input  logic                       sample_tick,
    input  logic                       cfg_we,
    input  logic [$clog2(NVOICES)-1:0] cfg_voice,
    input  logic [1:0]                 cfg_sel,
    input  logic [15:0]                cfg_data,
    output logic [BITDEPTH-1:0]        out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun
);

    // state  | meaning
    // IDLE   | waiting for sample_tick
    // RUN    | one voice per cycle, accumulating the mix
    // FINISH | saturate the mix and register out

    localparam int PW = BITDEPTH + BITFRACTION;
    localparam int VW = $clog2(NVOICES);
    localparam int AW = BITDEPTH + VW + 1;
    localparam int MW = BITDEPTH + 10;

    localparam logic [BITDEPTH-1:0]        MID_V  = {1'b1, {(BITDEPTH-1){1'b0}}};
    localparam logic [BITDEPTH-1:0]        MAX_V  = '1;
    localparam logic [BITDEPTH-1:0]        PW_RST = BITDEPTH'(1) << (BITDEPTH - 4);
    localparam logic signed [AW-1:0]       SAT_HI = AW'((1 << (BITDEPTH - 1)) - 1);
    localparam logic signed [AW-1:0]       SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t state, state_nxt;
    logic [VW-1:0] voice;

    logic [PW-1:0]       phase [NVOICES];
    logic [NVOICES-1:0]  sub;
    logic [15:0]         incr  [NVOICES];
    logic [2:0]          wave  [NVOICES];
    logic [BITDEPTH-1:0] pw    [NVOICES];
    logic [7:0]          gain  [NVOICES];
    logic signed [AW-1:0] acc;

    logic [PW-1:0]              cur_phase;
    logic [PW:0]                phase_sum;
    logic [BITDEPTH-1:0]        top, tri_bits, voice_val, voice_s;
    logic [9:0]                 gain_p1;
    logic [MW-1:0]              product;
    logic signed [BITDEPTH-1:0] term;
    logic signed [BITDEPTH-1:0] sat;
    logic                       unused_product_bits;

`ifdef OSCILLATOR_BANK_NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge sample_clock or negedge rst) begin
        if (!rst) begin
            lfsr <= 16'hACE1;
        end else if (state == S_RUN && wave[voice] == 3'd6) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
`endif

    always_ff @(posedge sample_clock or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (sample_tick) state_nxt = S_RUN;
            S_RUN:    if (voice == VW'(NVOICES - 1)) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_comb begin
        cur_phase = phase[voice];
        phase_sum = {1'b0, cur_phase} + {{(PW - 15){1'b0}}, incr[voice]};
        top       = cur_phase[PW-1 -: BITDEPTH];
        tri_bits  = cur_phase[PW-2 -: BITDEPTH];
        case (wave[voice])
            3'd1:    voice_val = top;
            3'd2:    voice_val = cur_phase[PW-1] ? ~tri_bits : tri_bits;
            3'd3:    voice_val = cur_phase[PW-1] ? MAX_V : '0;
            3'd4:    voice_val = (top < pw[voice]) ? MAX_V : '0;
            3'd5:    voice_val = sub[voice] ? MAX_V : '0;
`ifdef OSCILLATOR_BANK_NOISE_EN
            3'd6:    voice_val = lfsr[15 -: BITDEPTH];
`endif
            default: voice_val = MID_V;
        endcase
        voice_s = {~voice_val[BITDEPTH-1], voice_val[BITDEPTH-2:0]};
        gain_p1 = {2'b00, gain[voice]} + 10'd1;
        // Sign-extended operands so the low MW bits of an unsigned multiply are the signed product.
        product = {{10{voice_s[BITDEPTH-1]}}, voice_s} * {{BITDEPTH{1'b0}}, gain_p1};
        term    = product[BITDEPTH+7 -: BITDEPTH];
    end

    assign unused_product_bits = ^{product[MW-1 -: 2], product[7:0]};

    always_comb begin
        if (acc > SAT_HI)      sat = {1'b0, {(BITDEPTH-1){1'b1}}};
        else if (acc < SAT_LO) sat = {1'b1, {(BITDEPTH-1){1'b0}}};
        else                   sat = acc[BITDEPTH-1:0];
    end

    always_ff @(posedge sample_clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NVOICES; i++) begin
                phase[i] <= '0;
                incr[i]  <= '0;
                wave[i]  <= '0;
                pw[i]    <= PW_RST;
                gain[i]  <= 8'hFF;
            end
            sub       <= '0;
            acc       <= '0;
            voice     <= '0;
            out       <= MID_V;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= sample_tick && (state != S_IDLE);
            if (cfg_we && int'(cfg_voice) < NVOICES) begin
                case (cfg_sel)
                    2'd0:    incr[cfg_voice] <= cfg_data;
                    2'd1:    wave[cfg_voice] <= cfg_data[2:0];
                    2'd2:    pw[cfg_voice]   <= cfg_data[BITDEPTH-1:0];
                    default: gain[cfg_voice] <= cfg_data[7:0];
                endcase
            end
            case (state)
                S_IDLE: begin
                    voice <= '0;
                    if (sample_tick) acc <= '0;
                end
                S_RUN: begin
                    phase[voice] <= phase_sum[PW-1:0];
                    if (phase_sum[PW]) sub[voice] <= ~sub[voice];
                    acc   <= acc + $signed({{(AW - BITDEPTH){term[BITDEPTH-1]}}, term});
                    voice <= (voice == VW'(NVOICES - 1)) ? '0 : voice + 1'b1;
                end
                S_FINISH: begin
                    out       <= {~sat[BITDEPTH-1], sat[BITDEPTH-2:0]};
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oscillator_bank.sv
// Scoreboard bench for oscillator_bank: arithmetic reference model feeds a queue, a monitor checks each out_valid.
module tb_oscillator_bank;

    localparam int NV   = 4;
    localparam int BD   = 14;
    localparam int BF   = 8;
    localparam int PW   = BD + BF;
    localparam int FULL = 1 << PW;
    localparam int HALF = 1 << (PW - 1);
    localparam int MAXV = (1 << BD) - 1;
    localparam int MID  = 1 << (BD - 1);

    logic          sample_clock = 1'b0;
    logic          rst          = 1'b0;
    logic          sample_tick  = 1'b0;
    logic          cfg_we       = 1'b0;
    logic [1:0]    cfg_voice    = '0;
    logic [1:0]    cfg_sel      = '0;
    logic [15:0]   cfg_data     = '0;
    logic [BD-1:0] out;
    logic          out_valid;
    logic          busy;
    logic          overrun;

    oscillator_bank #(.NVOICES(NV), .BITDEPTH(BD), .BITFRACTION(BF)) dut (
        .sample_clock(sample_clock),
        .rst(rst),
        .sample_tick(sample_tick),
        .cfg_we(cfg_we),
        .cfg_voice(cfg_voice),
        .cfg_sel(cfg_sel),
        .cfg_data(cfg_data),
        .out(out),
        .out_valid(out_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 sample_clock = ~sample_clock;

    int cyc = 0;
    always @(posedge sample_clock) cyc <= cyc + 1;

    typedef struct {
        int value;
        int cycle;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   last_out    = MID;

    // Reference model state
    int m_phase[NV], m_sub[NV], m_inc[NV], m_wave[NV], m_pw[NV], m_gain[NV];
    int m_lfsr;

    task automatic check(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0; m_sub[v] = 0; m_inc[v] = 0;
            m_wave[v]  = 0; m_pw[v]  = 1 << (BD - 4); m_gain[v] = 255;
        end
        m_lfsr = 16'hACE1;
    endfunction

    function automatic int model_frame();
        int sum, val, top, lo, s;
        sum = 0;
        for (int v = 0; v < NV; v++) begin
            top = m_phase[v] / (1 << BF);
            lo  = (m_phase[v] % HALF) / (1 << (BF - 1));
            case (m_wave[v])
                1: val = top;
                2: val = (m_phase[v] >= HALF) ? MAXV - lo : lo;
                3: val = (m_phase[v] >= HALF) ? MAXV : 0;
                4: val = (top < m_pw[v]) ? MAXV : 0;
                5: val = (m_sub[v] != 0) ? MAXV : 0;
`ifdef OSCILLATOR_BANK_NOISE_EN
                6: begin
                    val    = m_lfsr >> (16 - BD);
                    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 16'hFFFF;
                end
`endif
                default: val = MID;
            endcase
            s   = val - MID;
            sum = sum + ((s * (m_gain[v] + 1)) >>> 8);
            m_phase[v] = m_phase[v] + m_inc[v];
            if (m_phase[v] >= FULL) begin
                m_phase[v] = m_phase[v] - FULL;
                m_sub[v]   = 1 - m_sub[v];
            end
        end
        if (sum > MID - 1) sum = MID - 1;
        if (sum < -MID)    sum = -MID;
        return sum + MID;
    endfunction

    // Monitor: every out_valid must match the oldest expected frame, on its expected cycle.
    always @(negedge sample_clock) begin
        if (!rst) begin
            last_out = MID;
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out_valid: got out=%0d with no frame pending (cycle %0d)", out, cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("out", int'(out), mon_e.value);
                check("out_valid_cycle", cyc, mon_e.cycle);
            end
            last_out = int'(out);
        end else begin
            check("out_stable", int'(out), last_out);
        end
    end

    // All stimulus tasks start and end at a falling edge.
    task automatic idle(int n);
        repeat (n) @(negedge sample_clock);
    endtask

    task automatic cfg_write(int v, int sel, int data);
        cfg_we = 1'b1; cfg_voice = 2'(v); cfg_sel = 2'(sel); cfg_data = 16'(data);
        case (sel)
            0: m_inc[v]  = data & 16'hFFFF;
            1: m_wave[v] = data & 7;
            2: m_pw[v]   = data & MAXV;
            default: m_gain[v] = data & 255;
        endcase
        @(negedge sample_clock);
        cfg_we = 1'b0;
    endtask

    task automatic tick();
        int e;
        e = model_frame();
        sbq.push_back(exp_t'{value: e, cycle: cyc + 6});
        sample_tick = 1'b1;
        @(negedge sample_clock);
        sample_tick = 1'b0;
    endtask

    task automatic tick_checked();
        tick();
        for (int k = 1; k <= 5; k++) begin
            check("busy_in_frame", int'(busy), 1);
            @(negedge sample_clock);
        end
        check("busy_after_frame", int'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sbq.delete();
        model_reset();
        idle(2);
        rst = 1'b1;
        idle(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c;
        model_reset();
        idle(3);
        check("reset_out", int'(out), MID);
        check("reset_busy", int'(busy), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        rst = 1'b1;
        idle(2);

        // Saw on voice 0, increment 0x4000, ticks 10 cycles apart
        cfg_write(0, 1, 1);
        cfg_write(0, 0, 16'h4000);
        repeat (3) begin
            tick_checked();
            idle(4);
        end

        // All pulse at phase 0 saturate high; all square at phase 0 saturate low
        do_reset();
        for (int v = 0; v < NV; v++) begin
            cfg_write(v, 1, 4);
            cfg_write(v, 2, 1024);
        end
        tick_checked();
        idle(2);
        do_reset();
        for (int v = 0; v < NV; v++) cfg_write(v, 1, 3);
        tick_checked();
        idle(2);

        // Overrun: second tick three cycles into a frame
        do_reset();
        cfg_write(2, 1, 2);
        cfg_write(2, 0, 16'h1234);
        c = cyc;
        tick();
        for (int k = 1; k <= 7; k++) begin
            if (k == 3) sample_tick = 1'b1;
            if (k > 1) check("overrun", int'(overrun), (cyc == c + 4) ? 1 : 0);
            @(negedge sample_clock);
            sample_tick = 1'b0;
        end
        idle(6);

        // Sub-octave with increment 0xFFFF across the first phase wrap
        do_reset();
        cfg_write(1, 1, 5);
        cfg_write(1, 0, 16'hFFFF);
        repeat (70) begin
            tick();
            idle(6);
        end

        // Reset in the middle of a frame
        do_reset();
        cfg_write(0, 1, 1);
        cfg_write(0, 0, 16'h3000);
        tick();
        idle(2);
        rst = 1'b0;
        sbq.delete();
        model_reset();
        #1;
        check("midreset_out", int'(out), MID);
        check("midreset_busy", int'(busy), 0);
        idle(2);
        rst = 1'b1;
        idle(10);
        cfg_write(0, 1, 1);
        cfg_write(0, 0, 16'h3000);
        repeat (2) begin
            tick_checked();
            idle(1);
        end

        // Waveform 6: noise when enabled, silent otherwise
        do_reset();
        cfg_write(0, 1, 6);
        tick_checked();
        idle(1);
        tick_checked();
        idle(1);

        // Randomized configuration and frames
        do_reset();
        repeat (250) begin
            tick();
            idle(5);
            repeat ($urandom_range(0, 3)) begin
                cfg_write($urandom_range(0, NV - 1), $urandom_range(0, 3), $urandom_range(0, 16'hFFFF));
            end
            idle($urandom_range(0, 3));
        end

        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge sample_clock);
        if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_out_valid: got %0d frames without output, expected 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
